// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ producer lanes, the arbiter and one stream consumer.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface stream_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        s_vld;
    logic [NUM_REQ*DATA_W-1:0] s_data;
    logic [NUM_REQ-1:0]        s_last;
    logic [NUM_REQ-1:0]        s_rdy;
    logic                      m_vld;
    logic [DATA_W-1:0]         m_data;
    logic                      m_last;
    logic                      m_rdy;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport slave (
        input  s_vld, s_data, s_last, m_rdy,
        output s_rdy, m_vld, m_data, m_last, grant_id, busy
    );

    modport master (
        output s_vld, s_data, s_last, m_rdy,
        input  s_rdy, m_vld, m_data, m_last, grant_id, busy
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_REQ valid/ready lanes share one consumer
// through a registered single-entry output stage.
module stream_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_rr_arbiter_if.slave bus
);
    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant_id;
    logic                busy;
    logic                m_vld;
    logic                m_last;
    logic [DATA_W-1:0]   m_data;

    logic [ID_W-1:0]     winner;
    logic                found;
    logic [NUM_REQ-1:0]  s_rdy;
    logic [LW-1:0]       sel;
    logic                stage_free;
    logic                lane_xfer;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    int                  idx;

    assign sel        = grant_id[LW-1:0];
    assign stage_free = !m_vld || bus.m_rdy;
    assign sel_data   = bus.s_data[sel*DATA_W +: DATA_W];
    assign sel_last   = bus.s_last[sel];
    assign lane_xfer  = bus.s_vld[sel] && s_rdy[sel];

    // First requester at or after ptr, wrapping past the top lane.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.s_vld[idx[LW-1:0]]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        s_rdy = '0;
        if (state == LOCKED && stage_free) s_rdy[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            m_vld    <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every update sees pre-edge values.
            if (lane_xfer) begin
                m_vld  <= 1'b1;
                m_data <= sel_data;
                m_last <= sel_last;
            end else if (m_vld && bus.m_rdy) begin
                m_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        busy     <= 1'b1;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Grant is released only when the end-of-packet beat is accepted.
                    if (lane_xfer && sel_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (grant_id == ID_W'(NUM_REQ - 1)) ptr <= '0;
                        else                                ptr <= grant_id + ID_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_rdy    = s_rdy;
    assign bus.m_vld    = m_vld;
    assign bus.m_data   = m_data;
    assign bus.m_last   = m_last;
    assign bus.grant_id = grant_id;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: scripted producer lanes, per-cycle expected
// snapshots of {m_vld, m_last, m_data, s_rdy, grant_id, busy} sampled on the falling edge.
module tb_stream_rr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    stream_rr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) bus ();

    stream_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [40:0] obs;
    assign obs = {bus.m_vld, bus.m_last, bus.m_data, bus.s_rdy, bus.grant_id, bus.busy};

    function automatic logic [40:0] pk(logic v, logic l, logic [31:0] d, logic [3:0] r,
                                       logic [1:0] g, logic b);
        return {v, l, d, r, g, b};
    endfunction

    // Producer lane model: each lane emits packets of p_len beats, data = base + 16*pkt + beat.
    bit          p_act  [NR];
    bit          p_rep  [NR];
    int          p_len  [NR];
    int          p_beat [NR];
    int          p_pkt  [NR];
    logic [31:0] p_base [NR];

    task automatic drive_lanes();
        for (int i = 0; i < NR; i++) begin
            bus.s_vld[i]          = p_act[i];
            bus.s_data[i*DW +: DW] = p_base[i] + 32'(p_pkt[i] * 16 + p_beat[i]);
            bus.s_last[i]         = (p_beat[i] == p_len[i] - 1);
        end
    endtask

    task automatic set_lane(int i, bit act, bit rep, int len, logic [31:0] base);
        p_act[i]  = act;
        p_rep[i]  = rep;
        p_len[i]  = len;
        p_base[i] = base;
        p_beat[i] = 0;
        p_pkt[i]  = 0;
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NR; i++) set_lane(i, 1'b0, 1'b0, 1, 32'h0);
    endtask

    // Called after the falling-edge sample: captures lane handshakes, crosses the edge.
    task automatic advance();
        logic [NR-1:0] x;
        x = bus.s_vld & bus.s_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (x[i]) begin
                if (p_beat[i] == p_len[i] - 1) begin
                    p_beat[i] = 0;
                    p_pkt[i]  = p_pkt[i] + 1;
                    if (!p_rep[i]) p_act[i] = 1'b0;
                end else begin
                    p_beat[i] = p_beat[i] + 1;
                end
            end
        end
        drive_lanes();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.m_rdy  = 1'b0;
        clear_lanes();
        drive_lanes();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) set_lane(i, 1'b1, 1'b1, 2, 32'h55);
        drive_lanes();
        bus.m_rdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_total++;
            if (obs !== pk(0, 0, 32'h0, 4'b0000, 2'd0, 0))
                $display("FAIL reset cycle %0d: got %h expected %h", c, obs, pk(0, 0, 32'h0, 4'b0000, 2'd0, 0));
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single_packet();
        logic [40:0] e [6];
        e = '{pk(0,0,32'h00,4'b0000,2'd0,0), pk(0,0,32'h00,4'b0100,2'd2,1),
              pk(1,0,32'hA0,4'b0100,2'd2,1), pk(1,0,32'hA1,4'b0100,2'd2,1),
              pk(1,1,32'hA2,4'b0000,2'd2,0), pk(0,1,32'hA2,4'b0000,2'd2,0)};
        do_reset();
        set_lane(2, 1'b1, 1'b0, 3, 32'hA0);
        for (int c = 0; c < 6; c++) begin
            bus.m_rdy = 1'b1;
            drive_lanes();
            @(negedge clk);
            n_total++;
            if (obs !== e[c]) $display("FAIL single_packet cycle %0d: got %h expected %h", c, obs, e[c]);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_round_robin();
        logic [40:0] e [16];
        e = '{pk(0,0,32'h000,4'b0000,2'd0,0), pk(0,0,32'h000,4'b0001,2'd0,1),
              pk(1,0,32'h000,4'b0001,2'd0,1), pk(1,1,32'h001,4'b0000,2'd0,0),
              pk(0,1,32'h001,4'b0010,2'd1,1), pk(1,0,32'h100,4'b0010,2'd1,1),
              pk(1,1,32'h101,4'b0000,2'd1,0), pk(0,1,32'h101,4'b0100,2'd2,1),
              pk(1,0,32'h200,4'b0100,2'd2,1), pk(1,1,32'h201,4'b0000,2'd2,0),
              pk(0,1,32'h201,4'b1000,2'd3,1), pk(1,0,32'h300,4'b1000,2'd3,1),
              pk(1,1,32'h301,4'b0000,2'd3,0), pk(0,1,32'h301,4'b0001,2'd0,1),
              pk(1,0,32'h010,4'b0001,2'd0,1), pk(1,1,32'h011,4'b0000,2'd0,0)};
        do_reset();
        for (int i = 0; i < NR; i++) set_lane(i, 1'b1, 1'b1, 2, 32'(i * 256));
        for (int c = 0; c < 16; c++) begin
            bus.m_rdy = 1'b1;
            drive_lanes();
            @(negedge clk);
            n_total++;
            if (obs !== e[c]) $display("FAIL round_robin cycle %0d: got %h expected %h", c, obs, e[c]);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [40:0] e [9];
        logic        r [9];
        e = '{pk(0,0,32'h00,4'b0000,2'd0,0), pk(0,0,32'h00,4'b0010,2'd1,1),
              pk(1,0,32'hB0,4'b0010,2'd1,1), pk(1,0,32'hB1,4'b0000,2'd1,1),
              pk(1,0,32'hB1,4'b0000,2'd1,1), pk(1,0,32'hB1,4'b0010,2'd1,1),
              pk(1,0,32'hB2,4'b0010,2'd1,1), pk(1,1,32'hB3,4'b0000,2'd1,0),
              pk(0,1,32'hB3,4'b0000,2'd1,0)};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        set_lane(1, 1'b1, 1'b0, 4, 32'hB0);
        for (int c = 0; c < 9; c++) begin
            bus.m_rdy = r[c];
            drive_lanes();
            @(negedge clk);
            n_total++;
            if (obs !== e[c]) $display("FAIL backpressure cycle %0d: got %h expected %h", c, obs, e[c]);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_grant_hold();
        logic [40:0] e [8];
        e = '{pk(0,0,32'h000,4'b0000,2'd0,0), pk(0,0,32'h000,4'b0001,2'd0,1),
              pk(1,0,32'h0C0,4'b0001,2'd0,1), pk(1,0,32'h0C1,4'b0001,2'd0,1),
              pk(1,1,32'h0C2,4'b0000,2'd0,0), pk(0,1,32'h0C2,4'b1000,2'd3,1),
              pk(1,1,32'h300,4'b0000,2'd3,0), pk(0,1,32'h300,4'b0001,2'd0,1)};
        do_reset();
        set_lane(0, 1'b1, 1'b1, 3, 32'hC0);
        for (int c = 0; c < 8; c++) begin
            bus.m_rdy = 1'b1;
            if (c == 2) set_lane(3, 1'b1, 1'b0, 1, 32'h300);
            drive_lanes();
            @(negedge clk);
            n_total++;
            if (obs !== e[c]) $display("FAIL grant_hold cycle %0d: got %h expected %h", c, obs, e[c]);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [40:0] e [6];
        e = '{pk(0,0,32'h00,4'b0000,2'd0,0), pk(0,0,32'h00,4'b0010,2'd1,1),
              pk(1,1,32'hF0,4'b0000,2'd1,0), pk(0,1,32'hF0,4'b0010,2'd1,1),
              pk(1,0,32'hE0,4'b0010,2'd1,1), pk(1,0,32'hE1,4'b0010,2'd1,1)};
        do_reset();
        set_lane(1, 1'b1, 1'b0, 1, 32'hF0);
        for (int c = 0; c < 6; c++) begin
            bus.m_rdy = 1'b1;
            if (c == 2) set_lane(1, 1'b1, 1'b0, 4, 32'hE0);
            drive_lanes();
            @(negedge clk);
            n_total++;
            if (obs !== e[c]) $display("FAIL reset_mid cycle %0d: got %h expected %h", c, obs, e[c]);
            else n_pass++;
            if (c < 5) advance();
        end
        // Asynchronous assertion between clock edges; outputs must clear without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (obs !== pk(0, 0, 32'h0, 4'b0000, 2'd0, 0))
            $display("FAIL reset_mid_async: got %h expected %h", obs, pk(0, 0, 32'h0, 4'b0000, 2'd0, 0));
        else n_pass++;
        set_lane(1, 1'b1, 1'b0, 4, 32'hE0);
        set_lane(3, 1'b1, 1'b0, 1, 32'h390);
        drive_lanes();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== pk(0, 0, 32'h0, 4'b0000, 2'd0, 0))
            $display("FAIL reset_mid_idle: got %h expected %h", obs, pk(0, 0, 32'h0, 4'b0000, 2'd0, 0));
        else n_pass++;
        advance();
        @(negedge clk);
        n_total++;
        if (obs !== pk(0, 0, 32'h0, 4'b0010, 2'd1, 1))
            $display("FAIL reset_mid_regrant: got %h expected %h", obs, pk(0, 0, 32'h0, 4'b0010, 2'd1, 1));
        else n_pass++;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [40:0] e [9];
        e = '{pk(0,0,32'h00,4'b0000,2'd0,0), pk(0,0,32'h00,4'b1000,2'd3,1),
              pk(1,1,32'h30,4'b0000,2'd3,0), pk(0,1,32'h30,4'b0001,2'd0,1),
              pk(1,1,32'h50,4'b0000,2'd0,0), pk(0,1,32'h50,4'b0001,2'd0,1),
              pk(1,1,32'h60,4'b0000,2'd0,0), pk(0,1,32'h60,4'b0001,2'd0,1),
              pk(1,1,32'h70,4'b0000,2'd0,0)};
        do_reset();
        set_lane(3, 1'b1, 1'b0, 1, 32'h30);
        for (int c = 0; c < 9; c++) begin
            bus.m_rdy = 1'b1;
            if (c == 1) set_lane(0, 1'b1, 1'b1, 1, 32'h50);
            drive_lanes();
            @(negedge clk);
            n_total++;
            if (obs !== e[c]) $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs, e[c]);
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        bus.m_rdy = 1'b0;
        clear_lanes();
        drive_lanes();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_grant_hold();
        test_reset_mid_packet();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
